// File: rtl/wb_skid_stage_reg_pkg.sv
// Shared types and sizing helpers for the MEM->WB skid stage register.
package wb_stage_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned DEST_W_DEF = 4;

  // Payload width: wb_en + mem_r_en + alu_result + mem_result + dest.
  localparam int unsigned PAYLOAD_W  = 2 + 2 * DATA_W_DEF + DEST_W_DEF;

  // Occupancy encoding doubles as the held-entry count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  // Payload layout at the default widths; the top rebuilds it per parameter set.
  typedef struct packed {
    logic                  wb_en;
    logic                  mem_r_en;
    logic [DATA_W_DEF-1:0] alu_result;
    logic [DATA_W_DEF-1:0] mem_result;
    logic [DEST_W_DEF-1:0] dest;
  } wb_payload_t;

  // Payload width for an arbitrary parameter set.
  function automatic int unsigned payload_w(input int unsigned data_w,
                                            input int unsigned dest_w);
    return 2 + 2 * data_w + dest_w;
  endfunction

endpackage

// File: rtl/wb_skid_stage_reg_if.sv
// Handshake and payload bundle between the memory stage, the skid register and write-back.
interface wb_skid_stage_reg_if
  import wb_stage_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEST_W = DEST_W_DEF
);

  // Upstream (memory stage) side.
  logic              in_valid;
  logic              in_ready;
  logic              wb_en_in;
  logic              mem_r_en_in;
  logic [DATA_W-1:0] alu_result_in;
  logic [DATA_W-1:0] mem_result_in;
  logic [DEST_W-1:0] dest_in;

  // Downstream (write-back) side.
  logic              out_valid;
  logic              out_ready;
  logic              wb_en_out;
  logic              mem_r_en_out;
  logic [DATA_W-1:0] alu_result_out;
  logic [DATA_W-1:0] mem_result_out;
  logic [DEST_W-1:0] dest_out;

  // Hazard visibility.
  logic              skid_valid;
  logic [DEST_W-1:0] skid_dest;
  logic [1:0]        occupancy;

  // Stage register view.
  modport slave (
    input  in_valid, wb_en_in, mem_r_en_in, alu_result_in, mem_result_in, dest_in,
    input  out_ready,
    output in_ready,
    output out_valid, wb_en_out, mem_r_en_out, alu_result_out, mem_result_out, dest_out,
    output skid_valid, skid_dest, occupancy
  );

  // Surrounding pipeline view (memory stage plus write-back).
  modport master (
    output in_valid, wb_en_in, mem_r_en_in, alu_result_in, mem_result_in, dest_in,
    output out_ready,
    input  in_ready,
    input  out_valid, wb_en_out, mem_r_en_out, alu_result_out, mem_result_out, dest_out,
    input  skid_valid, skid_dest, occupancy
  );

endinterface

// File: rtl/wb_skid_stage_reg_entry.sv
// One payload entry: loadable register cleared to zero by asynchronous reset.
module wb_entry_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_ld,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Capture on load only; contents are don't-care while the entry is invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_ld) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/wb_skid_stage_reg.sv
// MEM->WB stage register with registered in_ready and a one-deep skid entry.
module wb_skid_stage_reg
  import wb_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEST_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  wb_skid_stage_reg_if.slave  bus
);

  typedef struct packed {
    logic              wb_en;
    logic              mem_r_en;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] mem_result;
    logic [DEST_W-1:0] dest;
  } entry_t;

  localparam int unsigned ENTRY_W = payload_w(DATA_W, DEST_W);

  state_e r_state;
  state_e w_state_nxt;
  logic   r_in_ready;

  logic   w_in_fire;
  logic   w_out_fire;
  logic   w_out_valid;
  logic   w_main_ld;
  logic   w_main_sel_skid;
  logic   w_skid_ld;

  entry_t w_in_entry;
  entry_t w_main_d;
  entry_t w_main_q;
  entry_t w_skid_q;

  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_in_fire   = bus.in_valid & r_in_ready;
  assign w_out_fire  = w_out_valid & bus.out_ready;

  assign w_in_entry.wb_en      = bus.wb_en_in;
  assign w_in_entry.mem_r_en   = bus.mem_r_en_in;
  assign w_in_entry.alu_result = bus.alu_result_in;
  assign w_in_entry.mem_result = bus.mem_result_in;
  assign w_in_entry.dest       = bus.dest_in;

  // Next-state and entry-load decode; flush overrides every transition.
  always_comb begin
    w_state_nxt     = r_state;
    w_main_ld       = 1'b0;
    w_main_sel_skid = 1'b0;
    w_skid_ld       = 1'b0;

    case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_state_nxt = ST_ONE;
          w_main_ld   = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_main_ld   = 1'b1;
        end else if (w_in_fire) begin
          w_state_nxt = ST_TWO;
          w_skid_ld   = 1'b1;
        end else if (w_out_fire) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_out_fire) begin
          w_state_nxt     = ST_ONE;
          w_main_ld       = 1'b1;
          w_main_sel_skid = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase

    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_main_ld   = 1'b0;
      w_skid_ld   = 1'b0;
    end
  end

  // State and upstream ready; ready depends only on the registered next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_TWO);
    end
  end

  // Head refills from the skid entry when draining out of TWO, else from the input.
  assign w_main_d = w_main_sel_skid ? w_skid_q : w_in_entry;

  wb_entry_reg #(.W(ENTRY_W)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .i_ld  (w_main_ld),
    .i_d   (w_main_d),
    .o_q   (w_main_q)
  );

  wb_entry_reg #(.W(ENTRY_W)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .i_ld  (w_skid_ld),
    .i_d   (w_in_entry),
    .o_q   (w_skid_q)
  );

  assign bus.in_ready       = r_in_ready;
  assign bus.out_valid      = w_out_valid;
  // Stale head data must never write the register file.
  assign bus.wb_en_out      = w_main_q.wb_en & w_out_valid;
  assign bus.mem_r_en_out   = w_main_q.mem_r_en;
  assign bus.alu_result_out = w_main_q.alu_result;
  assign bus.mem_result_out = w_main_q.mem_result;
  assign bus.dest_out       = w_main_q.dest;
  assign bus.skid_valid     = (r_state == ST_TWO);
  assign bus.skid_dest      = w_skid_q.dest;
  assign bus.occupancy      = 2'(r_state);

endmodule

// File: tb/tb_wb_skid_stage_reg.sv
// Directed bench for wb_skid_stage_reg: vector table plus reset and wide-payload sequences.
module tb_wb_skid_stage_reg;

  logic clk;
  logic rst_n;
  logic flush;
  logic flush64;

  int n_tests;
  int n_fail;

  wb_skid_stage_reg_if #(.DATA_W(32), .DEST_W(4)) bus ();
  wb_skid_stage_reg_if #(.DATA_W(64), .DEST_W(5)) bus64 ();

  wb_skid_stage_reg #(.DATA_W(32), .DEST_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  wb_skid_stage_reg #(.DATA_W(64), .DEST_W(5)) dut64 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush64),
    .bus   (bus64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          iv;
    bit          ordy;
    bit          fl;
    logic [3:0]  d;
    logic [31:0] a;
    bit          e_irdy;
    bit          e_ov;
    logic [1:0]  e_occ;
    bit          e_sv;
    logic [3:0]  e_dout;
    logic [31:0] e_aout;
    bit          e_wbo;
    logic [3:0]  e_sdest;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  function automatic vec_t mk(bit iv, bit ordy, bit fl, logic [3:0] d, logic [31:0] a,
                              bit irdy, bit ov, logic [1:0] occ, bit sv,
                              logic [3:0] dout, logic [31:0] aout, bit wbo,
                              logic [3:0] sdest);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fl = fl; v.d = d; v.a = a;
    v.e_irdy = irdy; v.e_ov = ov; v.e_occ = occ; v.e_sv = sv;
    v.e_dout = dout; v.e_aout = aout; v.e_wbo = wbo; v.e_sdest = sdest;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " in_ready"},   64'(bus.in_ready),       64'd1);
    chk({tag, " out_valid"},  64'(bus.out_valid),      64'd0);
    chk({tag, " occupancy"},  64'(bus.occupancy),      64'd0);
    chk({tag, " skid_valid"}, 64'(bus.skid_valid),     64'd0);
    chk({tag, " skid_dest"},  64'(bus.skid_dest),      64'd0);
    chk({tag, " dest_out"},   64'(bus.dest_out),       64'd0);
    chk({tag, " alu_out"},    64'(bus.alu_result_out), 64'd0);
    chk({tag, " mem_out"},    64'(bus.mem_result_out), 64'd0);
    chk({tag, " wb_en_out"},  64'(bus.wb_en_out),      64'd0);
    chk({tag, " mem_r_en"},   64'(bus.mem_r_en_out),   64'd0);
  endtask

  task automatic drive(input bit iv, input bit ordy, input bit fl,
                       input logic [3:0] d, input logic [31:0] a);
    bus.in_valid      = iv;
    bus.out_ready     = ordy;
    flush             = fl;
    bus.dest_in       = d;
    bus.alu_result_in = a;
    bus.mem_result_in = a ^ 32'hFFFF_0000;
    bus.wb_en_in      = 1'b1;
    bus.mem_r_en_in   = d[0];
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    flush   = 1'b0;
    flush64 = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    bus64.in_valid      = 1'b0;
    bus64.out_ready     = 1'b0;
    bus64.wb_en_in      = 1'b0;
    bus64.mem_r_en_in   = 1'b0;
    bus64.alu_result_in = '0;
    bus64.mem_result_in = '0;
    bus64.dest_in       = '0;

    //            iv ordy fl  d     a          irdy ov occ sv dout  aout       wbo sdest
    // Back-to-back with out_ready high, then drain.
    vecs[0]  = mk(1, 1, 0, 4'd0,  32'h10,     1, 1, 2'd1, 0, 4'd0,  32'h10,  1, 4'd0);
    vecs[1]  = mk(1, 1, 0, 4'd0,  32'h11,     1, 1, 2'd1, 0, 4'd0,  32'h11,  1, 4'd0);
    vecs[2]  = mk(1, 1, 0, 4'd0,  32'h12,     1, 1, 2'd1, 0, 4'd0,  32'h12,  1, 4'd0);
    vecs[3]  = mk(0, 1, 0, 4'd0,  32'h0,      1, 0, 2'd0, 0, 4'd0,  32'h12,  0, 4'd0);
    // Three-cycle stall offering dest 1,2,3; release drains 1,2,3 in order.
    vecs[4]  = mk(1, 0, 0, 4'd1,  32'h21,     1, 1, 2'd1, 0, 4'd1,  32'h21,  1, 4'd0);
    vecs[5]  = mk(1, 0, 0, 4'd2,  32'h22,     0, 1, 2'd2, 1, 4'd1,  32'h21,  1, 4'd2);
    vecs[6]  = mk(1, 0, 0, 4'd3,  32'h23,     0, 1, 2'd2, 1, 4'd1,  32'h21,  1, 4'd2);
    vecs[7]  = mk(1, 1, 0, 4'd3,  32'h23,     1, 1, 2'd1, 0, 4'd2,  32'h22,  1, 4'd2);
    vecs[8]  = mk(1, 1, 0, 4'd3,  32'h23,     1, 1, 2'd1, 0, 4'd3,  32'h23,  1, 4'd2);
    vecs[9]  = mk(0, 1, 0, 4'd0,  32'h0,      1, 0, 2'd0, 0, 4'd3,  32'h23,  0, 4'd2);
    // Fill to TWO then flush with a transfer offered.
    vecs[10] = mk(1, 0, 0, 4'd4,  32'h24,     1, 1, 2'd1, 0, 4'd4,  32'h24,  1, 4'd2);
    vecs[11] = mk(1, 0, 0, 4'd5,  32'h25,     0, 1, 2'd2, 1, 4'd4,  32'h24,  1, 4'd5);
    vecs[12] = mk(1, 0, 1, 4'd6,  32'h26,     1, 0, 2'd0, 0, 4'd4,  32'h24,  0, 4'd5);
    // Flush in ONE with a live in_fire and out_fire: the offered entry is dropped.
    vecs[13] = mk(1, 1, 0, 4'd7,  32'h27,     1, 1, 2'd1, 0, 4'd7,  32'h27,  1, 4'd5);
    vecs[14] = mk(1, 1, 1, 4'd8,  32'h28,     1, 0, 2'd0, 0, 4'd7,  32'h27,  0, 4'd5);
    vecs[15] = mk(0, 1, 0, 4'd0,  32'h0,      1, 0, 2'd0, 0, 4'd7,  32'h27,  0, 4'd5);
    // Flush in EMPTY with in_fire, then a normal accept.
    vecs[16] = mk(1, 1, 1, 4'd9,  32'h29,     1, 0, 2'd0, 0, 4'd7,  32'h27,  0, 4'd5);
    vecs[17] = mk(1, 1, 0, 4'd10, 32'h2A,     1, 1, 2'd1, 0, 4'd10, 32'h2A,  1, 4'd5);

    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].d, vecs[i].a);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d in_ready", i),   64'(bus.in_ready),       64'(vecs[i].e_irdy));
      chk($sformatf("v%0d out_valid", i),  64'(bus.out_valid),      64'(vecs[i].e_ov));
      chk($sformatf("v%0d occupancy", i),  64'(bus.occupancy),      64'(vecs[i].e_occ));
      chk($sformatf("v%0d skid_valid", i), 64'(bus.skid_valid),     64'(vecs[i].e_sv));
      chk($sformatf("v%0d dest_out", i),   64'(bus.dest_out),       64'(vecs[i].e_dout));
      chk($sformatf("v%0d alu_out", i),    64'(bus.alu_result_out), 64'(vecs[i].e_aout));
      chk($sformatf("v%0d mem_out", i),    64'(bus.mem_result_out),
          64'(vecs[i].e_aout ^ 32'hFFFF_0000));
      chk($sformatf("v%0d mem_r_en", i),   64'(bus.mem_r_en_out),   64'(vecs[i].e_dout[0]));
      chk($sformatf("v%0d wb_en_out", i),  64'(bus.wb_en_out),      64'(vecs[i].e_wbo));
      chk($sformatf("v%0d skid_dest", i),  64'(bus.skid_dest),      64'(vecs[i].e_sdest));
    end

    // Move into TWO (head dest 10, skid dest 11).
    drive(1'b1, 1'b0, 1'b0, 4'd11, 32'h2B);
    @(posedge clk);
    #1;
    chk("two occupancy", 64'(bus.occupancy), 64'd2);
    chk("two skid_dest", 64'(bus.skid_dest), 64'd11);
    chk("two dest_out",  64'(bus.dest_out),  64'd10);

    // out_ready raised mid-cycle must not reach in_ready or the outputs.
    #2;
    bus.out_ready = 1'b1;
    #1;
    chk("comb in_ready",  64'(bus.in_ready),  64'd0);
    chk("comb out_valid", 64'(bus.out_valid), 64'd1);
    chk("comb dest_out",  64'(bus.dest_out),  64'd10);
    bus.out_ready = 1'b0;

    // Asynchronous reset pulse between edges while in TWO.
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async");
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post-reset out_valid", 64'(bus.out_valid), 64'd0);
    chk("post-reset in_ready",  64'(bus.in_ready),  64'd1);

    // Wide payload passes unaltered through the 64/5 instance.
    bus64.in_valid      = 1'b1;
    bus64.out_ready     = 1'b1;
    bus64.wb_en_in      = 1'b1;
    bus64.mem_r_en_in   = 1'b1;
    bus64.alu_result_in = 64'h0123_4567_89AB_CDEF;
    bus64.mem_result_in = 64'hDEAD_BEEF_CAFE_F00D;
    bus64.dest_in       = 5'd29;
    @(posedge clk);
    #1;
    bus64.in_valid = 1'b0;
    chk("w64 out_valid", 64'(bus64.out_valid),    64'd1);
    chk("w64 mem_out",   bus64.mem_result_out,    64'hDEAD_BEEF_CAFE_F00D);
    chk("w64 alu_out",   bus64.alu_result_out,    64'h0123_4567_89AB_CDEF);
    chk("w64 dest_out",  64'(bus64.dest_out),     64'd29);
    chk("w64 mem_r_en",  64'(bus64.mem_r_en_out), 64'd1);
    chk("w64 wb_en_out", 64'(bus64.wb_en_out),    64'd1);
    @(posedge clk);
    #1;
    chk("w64 drained out_valid", 64'(bus64.out_valid), 64'd0);
    chk("w64 drained wb_en_out", 64'(bus64.wb_en_out), 64'd0);
    chk("w64 stale mem_out",     bus64.mem_result_out, 64'hDEAD_BEEF_CAFE_F00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_skid_stage_reg.md
# wb_skid_stage_reg

Parametrised MEM→WB pipeline register with a valid/ready handshake and a two-entry skid buffer. It carries the write-back control bits, ALU result, memory read data and destination register index from the memory stage to write-back. Unlike a plain stage register, it can absorb one extra transfer while write-back stalls, keeps its upstream ready registered, and drops in-flight entries on a pipeline flush.

## Interface
Parameters:
- DATA_W, 32, width of the ALU result and memory read data.
- DEST_W, 4, width of the destination register index.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous flush; discards all held entries.
- in_valid  in  1  memory stage presents a transfer.
- in_ready  out  1  stage can accept a transfer; driven directly from a register.
- wb_en_in, mem_r_en_in  in  1 each  write-back enable and load-select.
- alu_result_in, mem_result_in  in  DATA_W each  ALU result and memory read data.
- dest_in  in  DEST_W  destination register index.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  write-back consumes the head entry.
- wb_en_out  out  1  head wb_en ANDed with out_valid.
- mem_r_en_out  out  1  head load-select.
- alu_result_out, mem_result_out  out  DATA_W each  head payload.
- dest_out  out  DEST_W  head destination index.
- skid_valid  out  1  second entry is occupied, for hazard visibility.
- skid_dest  out  DEST_W  destination index of the second entry.
- occupancy  out  2  number of held entries, 0 to 2.

## Operation
- Two payload entries: main (the head, which drives the outputs) and skid.
- Payload = {wb_en, mem_r_en, alu_result, mem_result, dest}.
- in_fire = in_valid & in_ready.
- out_fire = out_valid & out_ready.
- States: EMPTY (no entries), ONE (main only), TWO (main and skid).
- EMPTY:
  - in_fire → ONE, main ← input.
- ONE:
  - in_fire & out_fire → ONE, main ← input.
  - in_fire & !out_fire → TWO, skid ← input.
  - !in_fire & out_fire → EMPTY.
  - Otherwise hold.
- TWO (in_ready = 0, so in_fire cannot occur):
  - out_fire → ONE, main ← skid.
  - Otherwise hold.
- in_ready register ← 1 unless the next state is TWO.
- out_valid = state ≠ EMPTY.
- occupancy = 0, 1, 2 for EMPTY, ONE, TWO.
- Flush has priority over every transition:
  - Next state is EMPTY and in_ready ← 1.
  - A transfer presented in the flush cycle is discarded.
  - out_fire in the flush cycle still counts as consumed; write-back already sampled it.
- Payload registers load only when their entry is written. Invalid entries keep stale data; the data bits are don't-care when not valid.
- wb_en_out is gated by out_valid, so a stale head can never cause a register-file write.

## Timing
- Reset (rst_n = 0, asynchronous):
  - State EMPTY, in_ready = 1, out_valid = 0, skid_valid = 0, occupancy = 0.
  - All payload outputs = 0.
- Reset deassertion is synchronised externally. The first edge after release may accept a transfer.
- Latency: a transfer accepted at edge N appears on the outputs after edge N with out_valid = 1, i.e. one cycle, the same as a plain stage register.
- Throughput: one transfer per cycle when out_ready is held high; the skid entry is never used.
- A stall of k ≥ 1 cycles with continuous input:
  - Exactly one extra entry is accepted, at the first stall edge.
  - in_ready is low for the remaining stall cycles.
- After the stall releases:
  - in_ready returns to 1 one cycle after the out_fire that moves the state from TWO to ONE.
  - Order is preserved: main drains before skid.
- out_* may change only on a clock edge; there is no combinational path from in_* to out_*.
- in_ready has no combinational path from out_ready.
- Reset asserted mid-stall drops both entries immediately, with no handshake.

## Structure
- Shared package wb_stage_pkg holds:
  - State enum {EMPTY, ONE, TWO}.
  - Payload struct type.
  - Localparam PAYLOAD_W = 2 + 2·DATA_W + DEST_W.
- Sub-module wb_entry_reg:
  - PAYLOAD_W-wide register with a load enable and asynchronous active-low clear to 0.
  - Instantiated twice, for main and skid.
- Top level holds the state register, the in_ready register and the next-state and mux logic. The main entry's input mux selects between the input and the skid entry.

## Test plan
- Reset, then back-to-back inputs with out_ready = 1:
  - Drive alu_result = 0x10, 0x11, 0x12.
  - Outputs show 0x10, 0x11, 0x12 on consecutive cycles, each one cycle after acceptance.
  - in_ready stays 1 and occupancy stays ≤ 1.
- Stall:
  - out_ready = 0 for 3 cycles while inputs dest = 1, 2, 3 are offered.
  - dest 1 and 2 are accepted; skid_valid = 1, skid_dest = 2, in_ready = 0, occupancy = 2; dest 3 is held off.
  - On release, outputs show dest 1, then 2, then 3.
- Flush while in TWO:
  - Next cycle: out_valid = 0, occupancy = 0, in_ready = 1, wb_en_out = 0.
  - A transfer offered during the flush cycle never appears on the outputs.
- Simultaneous in_fire and out_fire in ONE:
  - Head is replaced with no bubble; skid_valid stays 0.
- Asynchronous reset pulse mid-clock while in TWO:
  - All outputs go to reset values before the next edge.
- DATA_W = 64, DEST_W = 5:
  - mem_result = 0xDEADBEEF_CAFEF00D passes through unaltered.
  - mem_r_en_out = 1 and wb_en_out = 1 on the output cycle.
